serial_cfg_tx: RTL and testbench
================================

// Module: serial_cfg_tx
// PURPOSE
//  Configuration transmitter for the analog backend serial port. Latches two gain
//  words (gainA1 2b, gainA2 3b) and forces the backend into reset (o_resetbAll low).
//  Releases reset, then shifts 5 bits LSB-first on o_sclk/o_sdin: gainA1[0..1], then gainA2[0..2].
//  Waits for the backend's i_ready, with a timeout; signals completion via o_done/o_timeout.
//  Sits in the digital control domain on i_clk; o_sclk is derived from i_clk by division.
// PARAMETERS
//  SCLK_HALF    2   i_clk cycles per o_sclk half-period (>=1)
//  RST_CYCLES   3   i_clk cycles o_resetbAll is held low per transfer (>=1)
//  RDY_TIMEOUT  64  i_clk cycles allowed in WAIT_RDY before timeout (>=1)
// PORTS
//  i_clk        in   1  system clock; all state on posedge
//  i_resetAll   in   1  asynchronous, active-high reset
//  i_start      in   1  start request; sampled in IDLE only
//  i_gainA1     in   2  gain word 1, latched on accepted start
//  i_gainA2     in   3  gain word 2, latched on accepted start
//  i_ready      in   1  backend ready, synchronous to i_clk
//  o_resetbAll  out  1  active-low reset to backend
//  o_sclk       out  1  serial clock; backend samples o_sdin on rising edge
//  o_sdin       out  1  serial data
//  o_busy       out  1  high from accepted start until o_done
//  o_done       out  1  one-cycle pulse at end of transfer (success or timeout)
//  o_timeout    out  1  sticky error flag; cleared by next accepted start
// BEHAVIOUR
//  Reset (async, immediate, including mid-transfer):
//   - state=IDLE; o_resetbAll=0, o_sclk=0, o_sdin=0, o_busy=0, o_done=0, o_timeout=0
//   - all counters and the shift register are cleared.
//  States: IDLE -> RST -> LO -> HI -> (LO | WAIT_RDY) -> IDLE.
//  IDLE: on posedge with i_start=1:
//   - shreg <= {gainA2,gainA1} (bit0 = gainA1[0])
//   - o_busy=1, o_timeout=0, o_resetbAll=0 -> RST
//   - o_resetbAll otherwise holds its last value (1 after any completed transfer).
//  RST: held RST_CYCLES cycles. On exit, in the same edge: o_resetbAll=1, o_sdin=shreg[0] -> LO.
//  LO: o_sclk=0 for SCLK_HALF cycles -> HI (o_sclk=1).
//  HI: o_sclk=1 for SCLK_HALF cycles. On exit: o_sclk=0, shift right, bitcnt++.
//   - bitcnt==5 -> WAIT_RDY, o_sdin=0
//   - else -> LO, o_sdin=next bit (data changes only on falling o_sclk)
//   - o_sdin is stable SCLK_HALF cycles before and after each rising edge.
//   - exactly 5 rising edges per transfer.
//  Transfer length: RST_CYCLES + 10*SCLK_HALF cycles from start accept to WAIT_RDY entry.
//  WAIT_RDY: counter from 0.
//   - i_ready=1 -> o_done=1 for one cycle, o_busy=0 -> IDLE
//   - counter reaches RDY_TIMEOUT with i_ready=0 -> o_timeout=1, o_done pulse, o_busy=0 -> IDLE
//   - i_ready=1 on the same edge as the count expires counts as success.
//  i_ready is ignored outside WAIT_RDY.
//  i_start is ignored while o_busy=1 (no queueing). A start on the o_done cycle is accepted
//  the following cycle if still asserted.
//  Gain inputs may change after start accept without affecting the transfer.
// TESTING
//  1 Reset: assert i_resetAll mid-HI -> all outputs 0 that cycle, state IDLE; release -> no activity.
//  2 gainA1=2'b01, gainA2=3'b110, start pulse (defaults):
//     - o_resetbAll low for 3 cycles
//     - sdin at the 5 sclk rises = 1,0,0,1,1
//     - WAIT_RDY entered 23 cycles after accept.
//  3 i_ready raised 5 cycles into WAIT_RDY -> o_done pulses once, o_busy falls, o_timeout=0.
//  4 i_ready held 0 -> o_timeout=1 and o_done after 64 cycles in WAIT_RDY; next start clears o_timeout.
//  5 i_start held high across a transfer -> second transfer begins the cycle after o_done, o_resetbAll re-pulses low.
//  6 SCLK_HALF=1, RST_CYCLES=1:
//     - o_sclk period 2 cycles, 5 rises
//     - WAIT_RDY 11 cycles after accept
//     - gain inputs changed mid-transfer do not alter sdin.

Source files
------------

// File: rtl/serial_cfg_tx.sv
// serial_cfg_tx: configuration transmitter for the analog backend serial port.
// On an accepted start it latches two gain words, holds the backend in reset,
// releases it, shifts five bits LSB-first (gainA1[0..1] then gainA2[0..2]) on
// o_sclk/o_sdin, then waits for the backend's ready with a timeout.
//
// Ports:
//   i_clk        system clock, all state on posedge
//   i_resetAll   asynchronous active-high reset
//   i_start      start request, sampled in idle only
//   i_gainA1     gain word 1 (2b), latched on accepted start
//   i_gainA2     gain word 2 (3b), latched on accepted start
//   i_ready      backend ready, only observed while waiting for it
//   o_resetbAll  active-low reset to the backend
//   o_sclk       serial clock, backend samples o_sdin on its rising edge
//   o_sdin       serial data, changes only on falling o_sclk
//   o_busy       high from accepted start until o_done
//   o_done       one-cycle pulse at end of transfer (success or timeout)
//   o_timeout    sticky timeout flag, cleared by the next accepted start
module serial_cfg_tx #(
  parameter int unsigned SCLK_HALF   = 2,
  parameter int unsigned RST_CYCLES  = 3,
  parameter int unsigned RDY_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_resetAll,
  input  logic       i_start,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  input  logic       i_ready,
  output logic       o_resetbAll,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout
);

  localparam int unsigned MaxA   = (SCLK_HALF > RST_CYCLES) ? SCLK_HALF : RST_CYCLES;
  localparam int unsigned MaxCnt = (MaxA > RDY_TIMEOUT) ? MaxA : RDY_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  typedef enum logic [2:0] {StIdle, StRst, StLo, StHi, StWaitRdy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [4:0]        shreg_q, shreg_d;
  logic              resetb_q, resetb_d;
  logic              sclk_q, sclk_d;
  logic              sdin_q, sdin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge i_clk or posedge i_resetAll) begin
    if (i_resetAll) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      resetb_q  <= 1'b0;
      sclk_q    <= 1'b0;
      sdin_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      resetb_q  <= resetb_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    resetb_d  = resetb_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          shreg_d   = {i_gainA2, i_gainA1};
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          resetb_d  = 1'b0;
          cnt_d     = '0;
          bitcnt_d  = '0;
          state_d   = StRst;
        end
      end

      StRst: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          // Release reset and present the first bit on the same edge.
          cnt_d    = '0;
          resetb_d = 1'b1;
          sdin_d   = shreg_q[0];
          state_d  = StLo;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StLo: begin
        if (cnt_q == CntW'(SCLK_HALF - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = StHi;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StHi: begin
        if (cnt_q == CntW'(SCLK_HALF - 1)) begin
          cnt_d    = '0;
          sclk_d   = 1'b0;
          shreg_d  = {1'b0, shreg_q[4:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd4) begin
            sdin_d  = 1'b0;
            state_d = StWaitRdy;
          end else begin
            // Next bit goes out on the falling edge, before the shift lands.
            sdin_d  = shreg_q[1];
            state_d = StLo;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitRdy: begin
        // Ready is checked first so a ready on the expiring edge is a success.
        if (i_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntW'(RDY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign o_resetbAll = resetb_q;
  assign o_sclk      = sclk_q;
  assign o_sdin      = sdin_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_serial_cfg_tx.sv
// Testbench for serial_cfg_tx. Instance 0 uses default parameters, instance 1
// uses SCLK_HALF=1, RST_CYCLES=1. Expected serial bits are pushed to a per-instance
// queue when a start is driven and popped by the monitor at each rising o_sclk.
module tb_serial_cfg_tx;

  logic       clk;
  logic       rst;
  logic       start_r [2];
  logic [1:0] g1_r    [2];
  logic [2:0] g2_r    [2];
  logic       ready_r [2];
  logic       resetb_w[2];
  logic       sclk_w  [2];
  logic       sdin_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       to_w    [2];

  int checks = 0;
  int errors = 0;

  bit sb0[$];
  bit sb1[$];

  // Monitor bookkeeping, cycles counted from the sample right after the accept edge.
  int ncyc = 0;
  int cyc[2], rises[2], falls[2], rstlow[2], wait_cyc[2], done_cyc[2], done_cnt[2];
  int last_rise[2], acc_abs[2], done_abs[2];
  logic p_sclk[2], p_sdin[2], p_busy[2], p_resetb[2], p_done[2];

  serial_cfg_tx u_dut0 (
    .i_clk      (clk),
    .i_resetAll (rst),
    .i_start    (start_r[0]),
    .i_gainA1   (g1_r[0]),
    .i_gainA2   (g2_r[0]),
    .i_ready    (ready_r[0]),
    .o_resetbAll(resetb_w[0]),
    .o_sclk     (sclk_w[0]),
    .o_sdin     (sdin_w[0]),
    .o_busy     (busy_w[0]),
    .o_done     (done_w[0]),
    .o_timeout  (to_w[0])
  );

  serial_cfg_tx #(
    .SCLK_HALF  (1),
    .RST_CYCLES (1),
    .RDY_TIMEOUT(64)
  ) u_dut1 (
    .i_clk      (clk),
    .i_resetAll (rst),
    .i_start    (start_r[1]),
    .i_gainA1   (g1_r[1]),
    .i_gainA2   (g2_r[1]),
    .i_ready    (ready_r[1]),
    .o_resetbAll(resetb_w[1]),
    .o_sclk     (sclk_w[1]),
    .o_sdin     (sdin_w[1]),
    .o_busy     (busy_w[1]),
    .o_done     (done_w[1]),
    .o_timeout  (to_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        p_sclk[d]   = 1'b0;
        p_sdin[d]   = 1'b0;
        p_busy[d]   = 1'b0;
        p_resetb[d] = 1'b0;
        p_done[d]   = 1'b0;
        wait_cyc[d] = -1;
      end else begin
        if (busy_w[d] && !p_busy[d]) begin
          cyc[d]      = 0;
          rises[d]    = 0;
          falls[d]    = 0;
          rstlow[d]   = 0;
          wait_cyc[d] = -1;
          acc_abs[d]  = ncyc;
        end else begin
          cyc[d]++;
        end
        if (busy_w[d] && !resetb_w[d]) rstlow[d]++;
        if (sclk_w[d] && !p_sclk[d]) begin
          if (rises[d] > 0) begin
            checks++;
            if (cyc[d] - last_rise[d] != ((d == 0) ? 4 : 2)) begin
              errors++;
              $display("FAIL sclk_period dut%0d: got %0d want %0d", d, cyc[d] - last_rise[d],
                       (d == 0) ? 4 : 2);
            end
          end
          rises[d]++;
          last_rise[d] = cyc[d];
          checks++;
          if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            errors++;
            $display("FAIL sb_underflow dut%0d: got extra rise %0d want none", d, rises[d]);
          end else begin
            bit expv;
            expv = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            if (sdin_w[d] !== expv) begin
              errors++;
              $display("FAIL sdin_bit dut%0d rise %0d: got %0b want %0b", d, rises[d],
                       sdin_w[d], expv);
            end
          end
        end
        if (!sclk_w[d] && p_sclk[d]) begin
          falls[d]++;
          if (falls[d] == 5) wait_cyc[d] = cyc[d];
        end
        if (sdin_w[d] !== p_sdin[d]) begin
          checks++;
          if (!(p_sclk[d] && !sclk_w[d]) && !(resetb_w[d] && !p_resetb[d])) begin
            errors++;
            $display("FAIL sdin_change dut%0d cyc %0d: got change want stable", d, cyc[d]);
          end
        end
        if (done_w[d]) begin
          checks++;
          if (p_done[d]) begin
            errors++;
            $display("FAIL done_width dut%0d: got 2+ cycles want 1", d);
          end
          done_cnt[d]++;
          done_cyc[d] = cyc[d];
          done_abs[d] = ncyc;
        end
        p_sclk[d]   = sclk_w[d];
        p_sdin[d]   = sdin_w[d];
        p_busy[d]   = busy_w[d];
        p_resetb[d] = resetb_w[d];
        p_done[d]   = done_w[d];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_start(input int d, input logic [1:0] a, input logic [2:0] b);
    tick();
    g1_r[d]    = a;
    g2_r[d]    = b;
    start_r[d] = 1'b1;
    if (d == 0) begin
      sb0.push_back(a[0]); sb0.push_back(a[1]);
      sb0.push_back(b[0]); sb0.push_back(b[1]); sb0.push_back(b[2]);
    end else begin
      sb1.push_back(a[0]); sb1.push_back(a[1]);
      sb1.push_back(b[0]); sb1.push_back(b[1]); sb1.push_back(b[2]);
    end
    tick();
    start_r[d] = 1'b0;
  endtask

  task automatic wait_entry(input int d, input int budget);
    for (int i = 0; i < budget && wait_cyc[d] < 0; i++) tick();
    checks++;
    if (wait_cyc[d] < 0) begin
      errors++;
      $display("FAIL wait_entry_bound dut%0d: got none want entry within %0d", d, budget);
    end
  endtask

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget && !done_w[d]; i++) tick();
    checks++;
    if (!done_w[d]) begin
      errors++;
      $display("FAIL done_bound dut%0d: got none want done within %0d", d, budget);
    end
  endtask

  task automatic test_reset();
    logic [5:0] o;
    int r;
    for (int d = 0; d < 2; d++) begin
      o = {resetb_w[d], sclk_w[d], sdin_w[d], busy_w[d], done_w[d], to_w[d]};
      checks++;
      if (o !== 6'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %b want 000000", d, o);
      end
    end
    rst = 1'b0;
    drive_start(0, 2'b11, 3'b111);
    for (int i = 0; i < 20 && !sclk_w[0]; i++) tick();
    tick();
    rst = 1'b1;
    #1;
    o = {resetb_w[0], sclk_w[0], sdin_w[0], busy_w[0], done_w[0], to_w[0]};
    checks++;
    if (o !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_hi: got %b want 000000", o);
    end
    tick();
    rst = 1'b0;
    sb0.delete();
    r = rises[0];
    repeat (20) tick();
    o = {resetb_w[0], sclk_w[0], sdin_w[0], busy_w[0], done_w[0], to_w[0]};
    checks++;
    if (o !== 6'b0 || rises[0] != r) begin
      errors++;
      $display("FAIL reset_quiet: got %b rises %0d want 000000 rises %0d", o, rises[0], r);
    end
  endtask

  task automatic test_transfer();
    ready_r[0] = 1'b0;
    drive_start(0, 2'b01, 3'b110);
    wait_entry(0, 60);
    checks++;
    if (rstlow[0] != 3) begin
      errors++;
      $display("FAIL rst_low_len: got %0d want 3", rstlow[0]);
    end
    checks++;
    if (wait_cyc[0] != 23) begin
      errors++;
      $display("FAIL wait_entry_cyc: got %0d want 23", wait_cyc[0]);
    end
    checks++;
    if (rises[0] != 5 || sb0.size() != 0) begin
      errors++;
      $display("FAIL rise_count: got %0d left %0d want 5 left 0", rises[0], sb0.size());
    end
  endtask

  task automatic test_ready();
    int dc;
    dc = done_cnt[0];
    repeat (4) tick();
    ready_r[0] = 1'b1;
    wait_done(0, 10);
    checks++;
    if (done_cyc[0] != 28 || busy_w[0] !== 1'b0 || to_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_done: got cyc %0d busy %b to %b want cyc 28 busy 0 to 0",
               done_cyc[0], busy_w[0], to_w[0]);
    end
    ready_r[0] = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt[0] != dc + 1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_once: got %0d pulses busy %b want 1 busy 0", done_cnt[0] - dc,
               busy_w[0]);
    end
  endtask

  task automatic test_timeout();
    ready_r[0] = 1'b0;
    drive_start(0, 2'b11, 3'b101);
    wait_entry(0, 60);
    wait_done(0, 100);
    checks++;
    if (done_cyc[0] - wait_cyc[0] != 64 || to_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len: got %0d to %b busy %b want 64 to 1 busy 0",
               done_cyc[0] - wait_cyc[0], to_w[0], busy_w[0]);
    end
    repeat (5) tick();
    checks++;
    if (to_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1", to_w[0]);
    end
    // Ready held through the whole next transfer must be ignored until wait.
    ready_r[0] = 1'b1;
    drive_start(0, 2'b00, 3'b010);
    checks++;
    if (to_w[0] !== 1'b0 || resetb_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: got to %b rstb %b busy %b want 0 0 1", to_w[0],
               resetb_w[0], busy_w[0]);
    end
    wait_done(0, 60);
    checks++;
    if (done_cyc[0] != 24 || rises[0] != 5 || to_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: got cyc %0d rises %0d to %b want 24 5 0", done_cyc[0],
               rises[0], to_w[0]);
    end
    ready_r[0] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int dabs;
    ready_r[0] = 1'b1;
    tick();
    g1_r[0] = 2'b10;
    g2_r[0] = 3'b001;
    repeat (2) begin
      sb0.push_back(1'b0); sb0.push_back(1'b1);
      sb0.push_back(1'b1); sb0.push_back(1'b0); sb0.push_back(1'b0);
    end
    start_r[0] = 1'b1;
    tick();
    wait_done(0, 60);
    dabs = done_abs[0];
    tick();
    checks++;
    if (busy_w[0] !== 1'b1 || acc_abs[0] != dabs + 1 || resetb_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy %b gap %0d rstb %b want 1 1 0", busy_w[0],
               acc_abs[0] - dabs, resetb_w[0]);
    end
    start_r[0] = 1'b0;
    wait_done(0, 60);
    checks++;
    if (rstlow[0] != 3 || rises[0] != 5 || sb0.size() != 0) begin
      errors++;
      $display("FAIL b2b_second: got rstlow %0d rises %0d left %0d want 3 5 0", rstlow[0],
               rises[0], sb0.size());
    end
    repeat (3) tick();
    checks++;
    if (busy_w[0] !== 1'b0 || resetb_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got busy %b rstb %b want 0 1", busy_w[0], resetb_w[0]);
    end
    ready_r[0] = 1'b0;
  endtask

  task automatic test_fast();
    ready_r[1] = 1'b1;
    drive_start(1, 2'b10, 3'b011);
    // Changing the gains after accept must not disturb the shifted bits.
    g1_r[1] = 2'b01;
    g2_r[1] = 3'b100;
    wait_entry(1, 30);
    checks++;
    if (wait_cyc[1] != 11 || rises[1] != 5 || rstlow[1] != 1) begin
      errors++;
      $display("FAIL fast_timing: got wait %0d rises %0d rstlow %0d want 11 5 1",
               wait_cyc[1], rises[1], rstlow[1]);
    end
    wait_done(1, 10);
    checks++;
    if (done_cyc[1] != 12 || sb1.size() != 0 || to_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL fast_done: got cyc %0d left %0d to %b want 12 0 0", done_cyc[1],
               sb1.size(), to_w[1]);
    end
    ready_r[1] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_r[d]  = 1'b0;
      g1_r[d]     = '0;
      g2_r[d]     = '0;
      ready_r[d]  = 1'b0;
      wait_cyc[d] = -1;
      cyc[d]      = 0;
      rises[d]    = 0;
      falls[d]    = 0;
      rstlow[d]   = 0;
      done_cyc[d] = 0;
      done_cnt[d] = 0;
      last_rise[d] = 0;
      acc_abs[d]  = 0;
      done_abs[d] = 0;
    end
    repeat (3) tick();
    test_reset();
    test_transfer();
    test_ready();
    test_timeout();
    test_back_to_back();
    test_fast();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
